// File: rtl/occ_rom_arbiter.sv
// Round-robin arbiter sharing one fixed-latency Occ ROM among four accelerator paths.
// Each path keeps one outstanding read; returned words are routed back by requester ID.
module occ_rom_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int ROM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_ce_1,
    input  logic              req_ce_2,
    input  logic              req_ce_3,
    input  logic              req_ce_4,
    input  logic [ADDR_W-1:0] req_addr_1,
    input  logic [ADDR_W-1:0] req_addr_2,
    input  logic [ADDR_W-1:0] req_addr_3,
    input  logic [ADDR_W-1:0] req_addr_4,
    output logic [DATA_W-1:0] rsp_data_1,
    output logic [DATA_W-1:0] rsp_data_2,
    output logic [DATA_W-1:0] rsp_data_3,
    output logic [DATA_W-1:0] rsp_data_4,
    output logic              rsp_valid_1,
    output logic              rsp_valid_2,
    output logic              rsp_valid_3,
    output logic              rsp_valid_4,
    output logic              rom_ce_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [DATA_W-1:0] rom_data_i,
    output logic [3:0]        busy_o,
    output logic [3:0]        err_o
);

    localparam int PIPE_D = ROM_LAT + 1;

    logic [3:0]        req_ce;
    logic [ADDR_W-1:0] req_addr [4];

    logic [3:0]        pend_q, pend_d;
    logic [3:0]        infl_q, infl_d;
    logic [3:0]        err_q, err_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [ADDR_W-1:0] addr_q [4];

    logic              rom_ce_q;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;

    logic [PIPE_D-1:0] pv_q;
    logic [1:0]        pid_q [PIPE_D];

    logic [DATA_W-1:0] rsp_data_q [4];
    logic [3:0]        rsp_vld_q;

    logic [3:0]        busy;
    logic [3:0]        accept;
    logic [3:0]        drop;
    logic              gnt_vld;
    logic [1:0]        gnt_id;
    logic [3:0]        gnt_oh;
    logic              ret_vld;
    logic [1:0]        ret_id;
    logic [3:0]        ret_oh;

    assign req_ce      = {req_ce_4, req_ce_3, req_ce_2, req_ce_1};
    assign req_addr[0] = req_addr_1;
    assign req_addr[1] = req_addr_2;
    assign req_addr[2] = req_addr_3;
    assign req_addr[3] = req_addr_4;

    assign busy   = pend_q | infl_q;
    assign accept = req_ce & ~busy;
    assign drop   = req_ce & busy;

    // Search begins one past the last granted path; ptr_q resets to path 4 so path 1 goes first.
    always_comb begin
        logic [1:0] idx;
        gnt_vld = 1'b0;
        gnt_id  = ptr_q;
        idx     = ptr_q;
        for (int i = 1; i <= 4; i++) begin
            idx = ptr_q + 2'(i);
            if (!gnt_vld && pend_q[idx]) begin
                gnt_vld = 1'b1;
                gnt_id  = idx;
            end
        end
    end

    assign gnt_oh  = gnt_vld ? (4'b0001 << gnt_id) : 4'b0000;
    assign ret_vld = pv_q[ROM_LAT];
    assign ret_id  = pid_q[ROM_LAT];
    assign ret_oh  = ret_vld ? (4'b0001 << ret_id) : 4'b0000;

    // A path is never pending and in flight at once, so grant and return never hit the same bit.
    always_comb begin
        pend_d     = (pend_q & ~gnt_oh) | accept;
        infl_d     = (infl_q | gnt_oh) & ~ret_oh;
        err_d      = err_q | drop;
        ptr_d      = gnt_vld ? gnt_id : ptr_q;
        rom_addr_d = gnt_vld ? addr_q[gnt_id] : rom_addr_q;
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (accept[k]) begin
                addr_q[k] <= req_addr[k];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q     <= '0;
            infl_q     <= '0;
            err_q      <= '0;
            ptr_q      <= 2'd3;
            rom_ce_q   <= 1'b0;
            rom_addr_q <= '0;
        end else begin
            pend_q     <= pend_d;
            infl_q     <= infl_d;
            err_q      <= err_d;
            ptr_q      <= ptr_d;
            rom_ce_q   <= gnt_vld;
            rom_addr_q <= rom_addr_d;
        end
    end

    // ID pipeline: stage i lines up with the ROM cycle i after rom_ce_o, head meets rom_data_i.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pv_q <= '0;
            for (int i = 0; i < PIPE_D; i++) begin
                pid_q[i] <= '0;
            end
        end else begin
            pv_q     <= {pv_q[PIPE_D-2:0], gnt_vld};
            pid_q[0] <= gnt_id;
            for (int i = 1; i < PIPE_D; i++) begin
                pid_q[i] <= pid_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_vld_q <= '0;
            for (int k = 0; k < 4; k++) begin
                rsp_data_q[k] <= '0;
            end
        end else begin
            rsp_vld_q <= ret_oh;
            if (ret_vld) begin
                rsp_data_q[ret_id] <= rom_data_i;
            end
        end
    end

    assign rom_ce_o    = rom_ce_q;
    assign rom_addr_o  = rom_addr_q;
    assign busy_o      = busy;
    assign err_o       = err_q;
    assign rsp_valid_1 = rsp_vld_q[0];
    assign rsp_valid_2 = rsp_vld_q[1];
    assign rsp_valid_3 = rsp_vld_q[2];
    assign rsp_valid_4 = rsp_vld_q[3];
    assign rsp_data_1  = rsp_data_q[0];
    assign rsp_data_2  = rsp_data_q[1];
    assign rsp_data_3  = rsp_data_q[2];
    assign rsp_data_4  = rsp_data_q[3];

endmodule
